// File: rtl/aes_cipher_rk_core.sv
// Iterative AES encryption core, one round per clock, round keys fetched by index from an external key store.
// Optional feature macro: AES_CIPHER_RK_STAT_EN adds the blk_cnt completed-block counter port.

module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] s
);

   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p;
      logic [7:0] v;
      p = 8'h00;
      v = x;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) p = p ^ v;
         v = {v[6:0], 1'b0} ^ (8'h1b & {8{v[7]}});
      end
      return p;
   endfunction

   logic [7:0] x2, x3, x12, x15, x240, inv;

   // Multiplicative inverse as a^254 (maps 0 to 0), then the affine transform.
   always_comb begin
      x2   = gf_mul(a, a);
      x3   = gf_mul(x2, a);
      x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
      x15  = gf_mul(x12, x3);
      x240 = gf_mul(x15, x15);
      x240 = gf_mul(x240, x240);
      x240 = gf_mul(x240, x240);
      x240 = gf_mul(x240, x240);
      inv  = gf_mul(gf_mul(x240, x12), x2);
      s    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end

endmodule

module aes_cipher_rk_core #(
   parameter int NR    = 10,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [127:0]     in_data,
   input  logic [TAG_W-1:0] in_tag,
   output logic [3:0]       rk_idx,
   input  logic [127:0]     rk,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     out_data,
   output logic [TAG_W-1:0] out_tag
`ifdef AES_CIPHER_RK_STAT_EN
   ,
   output logic [31:0]      blk_cnt
`endif
);

   if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_nr_check
      $error("aes_cipher_rk_core: NR must be 10, 12 or 14");
   end

   localparam logic [3:0] NR_L = 4'(NR);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ROUND,
      S_HOLD
   } state_t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] col);
      logic [7:0] a, b, c, d;
      {a, b, c, d} = col;
      return {xtime(a) ^ xtime(b) ^ b ^ c ^ d,
              a ^ xtime(b) ^ xtime(c) ^ c ^ d,
              a ^ b ^ xtime(c) ^ xtime(d) ^ d,
              xtime(a) ^ a ^ b ^ c ^ xtime(d)};
   endfunction

   state_t             fsm, fsm_nxt;
   logic [3:0]         rnd, rnd_nxt;
   logic [127:0]       st, st_nxt;
   logic [TAG_W-1:0]   tag_q, tag_nxt;
   logic               out_valid_nxt;
   logic [127:0]       out_data_nxt;
   logic [TAG_W-1:0]   out_tag_nxt;
   logic [127:0]       sb_out, sr_out, mc_out;

   // Byte i sits at [127-8i -: 8] and is s(i%4, i/4).
   for (genvar i = 0; i < 16; i++) begin : g_sub
      aes_sbox u_sbox (
         .a (st[127-8*i -: 8]),
         .s (sb_out[127-8*i -: 8])
      );
   end

   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign sr_out[127-8*(4*c+r) -: 8] = sb_out[127-8*(4*((c+r)%4)+r) -: 8];
      end
      assign mc_out[127-32*c -: 32] = mix_col(sr_out[127-32*c -: 32]);
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves a latch.
      fsm_nxt       = fsm;
      rnd_nxt       = rnd;
      st_nxt        = st;
      tag_nxt       = tag_q;
      out_valid_nxt = out_valid;
      out_data_nxt  = out_data;
      out_tag_nxt   = out_tag;
      in_ready      = 1'b0;
      rk_idx        = 4'd0;
      case (fsm)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               st_nxt  = in_data ^ rk;
               tag_nxt = in_tag;
               rnd_nxt = 4'd1;
               fsm_nxt = S_ROUND;
            end
         end
         S_ROUND: begin
            rk_idx = rnd;
            if (rnd == NR_L) begin
               out_data_nxt  = sr_out ^ rk;
               out_tag_nxt   = tag_q;
               out_valid_nxt = 1'b1;
               fsm_nxt       = S_HOLD;
            end else begin
               st_nxt  = mc_out ^ rk;
               rnd_nxt = rnd + 4'd1;
            end
         end
         S_HOLD: begin
            rk_idx = NR_L;
            if (out_ready) begin
               out_valid_nxt = 1'b0;
               fsm_nxt       = S_IDLE;
            end
         end
         default: fsm_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (!rst) begin
         fsm       <= S_IDLE;
         rnd       <= 4'd0;
         st        <= '0;
         tag_q     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_tag   <= '0;
      end else begin
         fsm       <= fsm_nxt;
         rnd       <= rnd_nxt;
         st        <= st_nxt;
         tag_q     <= tag_nxt;
         out_valid <= out_valid_nxt;
         out_data  <= out_data_nxt;
         out_tag   <= out_tag_nxt;
      end
   end

`ifdef AES_CIPHER_RK_STAT_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         blk_cnt <= 32'd0;
      end else if (out_valid && out_ready) begin
         blk_cnt <= blk_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_aes_cipher_rk_core.sv
// Self-checking bench: three cores (NR=10/12/14) fed from bench-built key stores, FIPS-197 vectors,
// scoreboard on the output handshake, backpressure, mid-block reset and optional blk_cnt checks.

module tb_aes_cipher_rk_core;

   localparam int TAG_W = 4;

   typedef struct {
      int               inst;
      logic [255:0]     key;
      logic [127:0]     pt;
      logic [127:0]     ct;
      logic [TAG_W-1:0] tag;
      bit               busy;
   } vec_t;

   typedef struct {
      int               inst;
      logic [127:0]     ct;
      logic [TAG_W-1:0] tag;
   } exp_t;

   localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
   localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [255:0] KEYB   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] PTB    = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] CTB    = 128'h3925841d02dc09fbdc118597196a0b32;

   logic                   clk, rst;
   logic [2:0]             in_valid, in_ready, out_valid, out_ready;
   logic [2:0][127:0]      in_data, rk, out_data;
   logic [2:0][TAG_W-1:0]  in_tag, out_tag;
   logic [2:0][3:0]        rk_idx;
`ifdef AES_CIPHER_RK_STAT_EN
   logic [2:0][31:0]       blk_cnt;
`endif

   logic [127:0] rkeys [3][15];
   logic [7:0]   sbox_t [256];
   exp_t         sb [$];
   int           exp_cnt [3];
   int           checks, errors;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      aes_cipher_rk_core #(.NR(10 + 2*g), .TAG_W(TAG_W)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_data   (in_data[g]),
         .in_tag    (in_tag[g]),
         .rk_idx    (rk_idx[g]),
         .rk        (rk[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .out_data  (out_data[g]),
         .out_tag   (out_tag[g])
`ifdef AES_CIPHER_RK_STAT_EN
         ,
         .blk_cnt   (blk_cnt[g])
`endif
      );
   end

   // Key store: combinational lookup by the requested index.
   always_comb begin
      for (int k = 0; k < 3; k++) begin
         rk[k] = (rk_idx[k] <= 4'd14) ? rkeys[k][rk_idx[k]] : '0;
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p = 8'h00;
      logic [7:0] v = x;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) p = p ^ v;
         v = xt(v);
      end
      return p;
   endfunction

   // Table built by brute-force inverse search.
   task automatic init_sbox();
      logic [7:0] inv;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++) begin
            if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         end
         sbox_t[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
   endfunction

   task automatic expand_key(input int k, input logic [255:0] key, input int nr);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc;
      int          nk;
      nk = nr - 6;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end else if (nk > 6 && i % nk == 4) begin
            t = sub_word(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r < 15; r++) begin
         rkeys[k][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
      end
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting on the DUT", name);
   endtask

   // Output monitor: a handshake is pending when valid and ready are both high between edges.
   task automatic observe();
      exp_t e;
      for (int k = 0; k < 3; k++) begin
         if (rst && out_valid[k] && out_ready[k]) begin
            exp_cnt[k]++;
            if (sb.size() == 0) begin
               fail_timeout($sformatf("unexpected output on core %0d", k));
            end else begin
               e = sb.pop_front();
               check($sformatf("sb core %0d", k), 128'(k), 128'(e.inst));
               check($sformatf("sb data core %0d", k), out_data[k], e.ct);
               check($sformatf("sb tag core %0d", k), 128'(out_tag[k]), 128'(e.tag));
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      observe();
   endtask

   task automatic start_block(input int k, input logic [127:0] pt, input logic [TAG_W-1:0] tag,
                              input logic [127:0] ct);
      exp_t e;
      int n = 0;
      while (!in_ready[k] && n < 50) begin
         tick();
         n++;
      end
      if (!in_ready[k]) fail_timeout("in_ready");
      in_valid[k] = 1'b1;
      in_data[k]  = pt;
      in_tag[k]   = tag;
      e.inst = k;
      e.ct   = ct;
      e.tag  = tag;
      sb.push_back(e);
   endtask

   // Cycle 0 presents the block; out_valid must rise in cycle NR+1, rk_idx walks 0..NR.
   task automatic run_vec(input vec_t v);
      int  k, nr, cyc;
      bit  done;
      k  = v.inst;
      nr = 10 + 2*k;
      expand_key(k, v.key, nr);
      start_block(k, v.pt, v.tag, v.ct);
      cyc  = 0;
      done = 1'b0;
      check("rk_idx idle", 128'(rk_idx[k]), 128'd0);
      for (int n = 0; n < 40 && !done; n++) begin
         tick();
         cyc++;
         if (v.busy) begin
            in_data[k] = {$urandom, $urandom, $urandom, $urandom};
            in_tag[k]  = ~v.tag;
         end else begin
            in_valid[k] = 1'b0;
         end
         if (out_valid[k]) begin
            check("latency", 128'(cyc), 128'(nr + 1));
            check("rk_idx hold", 128'(rk_idx[k]), 128'(nr));
            in_valid[k] = 1'b0;
            done = 1'b1;
         end else begin
            check($sformatf("rk_idx cyc %0d", cyc), 128'(rk_idx[k]), 128'(cyc));
            check("in_ready round", 128'(in_ready[k]), 128'd0);
         end
      end
      in_valid[k] = 1'b0;
      if (!done) fail_timeout("out_valid");
      tick();
      check("out_valid after handshake", 128'(out_valid[k]), 128'd0);
      check("in_ready after handshake", 128'(in_ready[k]), 128'd1);
      check("scoreboard drained", 128'(sb.size()), 128'd0);
   endtask

   task automatic apply_reset(input int cycles);
      rst = 1'b0;
      for (int i = 0; i < cycles; i++) tick();
      sb.delete();
      for (int k = 0; k < 3; k++) exp_cnt[k] = 0;
   endtask

   initial begin
      vec_t vtab [6];
      vtab[0] = '{inst: 0, key: KEY128, pt: PT,  ct: CT128, tag: 4'h3, busy: 1'b0};
      vtab[1] = '{inst: 1, key: KEY192, pt: PT,  ct: CT192, tag: 4'h9, busy: 1'b0};
      vtab[2] = '{inst: 2, key: KEY256, pt: PT,  ct: CT256, tag: 4'hc, busy: 1'b1};
      vtab[3] = '{inst: 0, key: KEYB,   pt: PTB, ct: CTB,   tag: 4'hf, busy: 1'b1};
      vtab[4] = '{inst: 0, key: KEY128, pt: PT,  ct: CT128, tag: 4'h0, busy: 1'b0};
      vtab[5] = '{inst: 1, key: KEY192, pt: PT,  ct: CT192, tag: 4'h7, busy: 1'b1};

      checks    = 0;
      errors    = 0;
      in_valid  = '0;
      in_data   = '0;
      in_tag    = '0;
      out_ready = '1;
      for (int k = 0; k < 3; k++) for (int r = 0; r < 15; r++) rkeys[k][r] = '0;
      init_sbox();

      rst = 1'b0;
      apply_reset(3);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("reset out_valid %0d", k), 128'(out_valid[k]), 128'd0);
         check($sformatf("reset out_data %0d", k), out_data[k], 128'd0);
         check($sformatf("reset out_tag %0d", k), 128'(out_tag[k]), 128'd0);
         check($sformatf("reset in_ready %0d", k), 128'(in_ready[k]), 128'd1);
         check($sformatf("reset rk_idx %0d", k), 128'(rk_idx[k]), 128'd0);
      end
      rst = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) run_vec(vtab[i]);

      // Backpressure: result and tag held for 5 stalled cycles.
      expand_key(0, KEY128, 10);
      out_ready[0] = 1'b0;
      start_block(0, PT, 4'ha, CT128);
      tick();
      in_valid[0] = 1'b0;
      for (int n = 0; n < 30 && !out_valid[0]; n++) tick();
      if (!out_valid[0]) fail_timeout("backpressure out_valid");
      for (int n = 0; n < 5; n++) begin
         check("bp out_valid", 128'(out_valid[0]), 128'd1);
         check("bp out_data", out_data[0], CT128);
         check("bp out_tag", 128'(out_tag[0]), 128'ha);
         check("bp in_ready", 128'(in_ready[0]), 128'd0);
         tick();
      end
      out_ready[0] = 1'b1;
      observe();
      tick();
      check("bp release out_valid", 128'(out_valid[0]), 128'd0);
      check("bp release in_ready", 128'(in_ready[0]), 128'd1);
      run_vec('{inst: 0, key: KEY128, pt: PT, ct: CT128, tag: 4'h5, busy: 1'b0});

      // Reset during round 4 drops the block.
      start_block(0, PT, 4'h6, CT128);
      tick();
      in_valid[0] = 1'b0;
      for (int n = 0; n < 20 && rk_idx[0] != 4'd4; n++) tick();
      check("reached round 4", 128'(rk_idx[0]), 128'd4);
      apply_reset(1);
      check("mid reset out_valid", 128'(out_valid[0]), 128'd0);
      check("mid reset in_ready", 128'(in_ready[0]), 128'd1);
      check("mid reset rk_idx", 128'(rk_idx[0]), 128'd0);
      rst = 1'b1;
      for (int n = 0; n < 14; n++) begin
         tick();
         check("dropped block stays silent", 128'(out_valid[0]), 128'd0);
      end
      run_vec(vtab[0]);

`ifdef AES_CIPHER_RK_STAT_EN
      for (int k = 0; k < 3; k++) begin
         check($sformatf("blk_cnt model %0d", k), 128'(blk_cnt[k]), 128'(exp_cnt[k]));
      end
      apply_reset(2);
      rst = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) run_vec(vtab[i == 1 ? 3 : 0]);
      check("blk_cnt after 3", 128'(blk_cnt[0]), 128'd3);
      force g_dut[0].u_dut.blk_cnt = 32'hffff_ffff;
      #1;
      release g_dut[0].u_dut.blk_cnt;
      check("blk_cnt preload", 128'(blk_cnt[0]), 128'hffff_ffff);
      run_vec(vtab[0]);
      check("blk_cnt wrap", 128'(blk_cnt[0]), 128'd0);
`endif

      check("scoreboard empty at end", 128'(sb.size()), 128'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
